// File: rtl/i2c_byte_master_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_byte_master_if
// Description : Request/response handshake between the BMP180 controller and
//               the I2C byte engine, plus the open-drain pin controls.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_byte_master_if;
  logic       start;
  logic       send;
  logic       receive;
  logic [7:0] datasend;
  logic       sended;
  logic [7:0] datareceive;
  logic       received;
  logic       isReady;
  logic       ackErr;
  logic       sda_in;
  logic       scl_oe;
  logic       sda_oe;

  // Byte engine side
  modport master (
    input  start, send, receive, datasend, sda_in,
    output sended, datareceive, received, isReady, ackErr, scl_oe, sda_oe
  );

  // Controller / board side
  modport slave (
    output start, send, receive, datasend, sda_in,
    input  sended, datareceive, received, isReady, ackErr, scl_oe, sda_oe
  );
endinterface
`default_nettype wire

// File: rtl/i2c_byte_master.sv
`default_nettype none
// ============================================================================
// Module      : i2c_byte_master
// Description : Single-master I2C byte engine. Generates START / repeated
//               START / STOP, shifts bytes out and in MSB first, and opens a
//               sended/received window after every byte so the controller can
//               choose the next action. SCL/SDA are open-drain enables.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_byte_master #(
  parameter int QDIV  = 125,  // clk cycles per SCL quarter period, >= 2
  parameter int TOG_W = 8     // quarter counter width, must hold QDIV-1
) (
  input  logic              clk,
  input  logic              reset,
  i2c_byte_master_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_START    = 4'd1,
    S_TX_BIT   = 4'd2,
    S_TX_ACK   = 4'd3,
    S_SEND_WIN = 4'd4,
    S_RSTART   = 4'd5,
    S_RX_BIT   = 4'd6,
    S_RECV_WIN = 4'd7,
    S_RX_ACK   = 4'd8,
    S_STOP     = 4'd9
  } state_t;

  localparam logic [TOG_W-1:0] c_qLast = TOG_W'(QDIV - 1);

  state_t           r_state;
  logic [TOG_W-1:0] r_qCnt;
  logic [1:0]       r_phase;
  logic [2:0]       r_bitCnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_datareceive;
  logic             r_isAddr;      // byte in flight was loaded by START/Sr
  logic             r_rwBit;       // R/W bit of that address byte
  logic             r_ackErr;
  logic             r_ackBit;      // 1 = master ACKs the byte just read
  logic             r_sdaMeta;
  logic             r_sdaSync;
  logic             r_sclOe;
  logic             r_sdaOe;
  logic             r_sended;
  logic             r_received;
  logic             r_isReady;

  logic             w_tick;
  logic             w_lastQ;
  logic             w_bitSclLow;
  logic             w_sclOe;
  logic             w_sdaOe;

  assign w_tick      = (r_state != S_IDLE) && (r_qCnt == c_qLast);
  assign w_lastQ     = w_tick && (r_phase == 2'd3);
  // Bit cell: SCL low in q0 and q3, high in q1 and q2
  assign w_bitSclLow = (r_phase == 2'd0) || (r_phase == 2'd3);

  // Pin levels wanted for the current state/quarter (registered below)
  always_comb begin
    w_sclOe = 1'b0;
    w_sdaOe = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_sclOe = 1'b0;
        w_sdaOe = 1'b0;
      end
      // SDA falls while SCL is high; SCL is pulled low in the second quarter
      // so the first data bit never changes SDA while SCL is still high.
      S_START: begin
        w_sclOe = (r_phase != 2'd0);
        w_sdaOe = 1'b1;
      end
      S_TX_BIT: begin
        w_sclOe = w_bitSclLow;
        w_sdaOe = ~r_shift[7];
      end
      S_TX_ACK, S_RX_BIT: begin
        w_sclOe = w_bitSclLow;
        w_sdaOe = 1'b0;
      end
      S_SEND_WIN, S_RECV_WIN: begin
        w_sclOe = 1'b1;
        w_sdaOe = 1'b0;
      end
      // Released SDA, SCL up, SDA down (Sr), SCL down
      S_RSTART: begin
        w_sclOe = w_bitSclLow;
        w_sdaOe = r_phase[1];
      end
      S_RX_ACK: begin
        w_sclOe = w_bitSclLow;
        w_sdaOe = r_ackBit;
      end
      // SDA low with SCL low, SCL up, then SDA released while SCL high (P)
      S_STOP: begin
        w_sclOe = (r_phase == 2'd0);
        w_sdaOe = ~r_phase[1];
      end
      default: begin
        w_sclOe = 1'b0;
        w_sdaOe = 1'b0;
      end
    endcase
  end

  // Sequencer: quarter timebase, bit/byte handling, windows and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_qCnt        <= '0;
      r_phase       <= 2'd0;
      r_bitCnt      <= 3'd0;
      r_shift       <= 8'h00;
      r_datareceive <= 8'h00;
      r_isAddr      <= 1'b0;
      r_rwBit       <= 1'b0;
      r_ackErr      <= 1'b0;
      r_ackBit      <= 1'b0;
      r_sdaMeta     <= 1'b1;
      r_sdaSync     <= 1'b1;
      r_sclOe       <= 1'b0;
      r_sdaOe       <= 1'b0;
      r_sended      <= 1'b0;
      r_received    <= 1'b0;
      r_isReady     <= 1'b0;
    end else begin
      r_sdaMeta  <= bus.sda_in;
      r_sdaSync  <= r_sdaMeta;
      r_sclOe    <= w_sclOe;
      r_sdaOe    <= w_sdaOe;
      r_sended   <= (r_state == S_SEND_WIN);
      r_received <= (r_state == S_RECV_WIN);
      r_isReady  <= (r_state == S_IDLE);

      if ((r_state == S_IDLE) || w_tick) r_qCnt <= '0;
      else                               r_qCnt <= r_qCnt + 1'b1;

      if (r_state == S_IDLE) r_phase <= 2'd0;
      else if (w_tick)       r_phase <= r_phase + 2'd1;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_shift  <= bus.datasend;
            r_isAddr <= 1'b1;
            r_rwBit  <= bus.datasend[0];
            r_ackErr <= 1'b0;
            r_state  <= S_START;
          end
        end

        S_START: begin
          if (w_tick && (r_phase == 2'd1)) begin
            r_phase  <= 2'd0;
            r_bitCnt <= 3'd0;
            r_state  <= S_TX_BIT;
          end
        end

        S_TX_BIT: begin
          if (w_lastQ) begin
            r_shift <= {r_shift[6:0], 1'b0};
            if (r_bitCnt == 3'd7) begin
              r_bitCnt <= 3'd0;
              r_state  <= S_TX_ACK;
            end else begin
              r_bitCnt <= r_bitCnt + 3'd1;
            end
          end
        end

        S_TX_ACK: begin
          if (w_tick && (r_phase == 2'd2) && r_sdaSync) r_ackErr <= 1'b1;
          if (w_lastQ) r_state <= S_SEND_WIN;
        end

        // After a NACK only a read following a read-address may continue
        S_SEND_WIN: begin
          if (w_lastQ) begin
            r_bitCnt <= 3'd0;
            if (r_ackErr) begin
              if (r_isAddr && r_rwBit && bus.receive) r_state <= S_RX_BIT;
              else                                    r_state <= S_STOP;
            end else if (bus.start) begin
              r_shift  <= bus.datasend;
              r_isAddr <= 1'b1;
              r_rwBit  <= bus.datasend[0];
              r_state  <= S_RSTART;
            end else if (bus.send) begin
              r_shift  <= bus.datasend;
              r_isAddr <= 1'b0;
              r_state  <= S_TX_BIT;
            end else if (bus.receive) begin
              r_state  <= S_RX_BIT;
            end else begin
              r_state  <= S_STOP;
            end
          end
        end

        S_RSTART: begin
          if (w_lastQ) begin
            r_bitCnt <= 3'd0;
            r_state  <= S_TX_BIT;
          end
        end

        S_RX_BIT: begin
          if (w_tick && (r_phase == 2'd2)) r_shift <= {r_shift[6:0], r_sdaSync};
          if (w_lastQ) begin
            if (r_bitCnt == 3'd7) begin
              r_bitCnt      <= 3'd0;
              r_datareceive <= r_shift;
              r_state       <= S_RECV_WIN;
            end else begin
              r_bitCnt <= r_bitCnt + 3'd1;
            end
          end
        end

        S_RECV_WIN: begin
          if (w_lastQ) begin
            r_ackBit <= bus.receive;
            r_state  <= S_RX_ACK;
          end
        end

        S_RX_ACK: begin
          if (w_lastQ) begin
            r_bitCnt <= 3'd0;
            r_state  <= r_ackBit ? S_RX_BIT : S_STOP;
          end
        end

        S_STOP: begin
          if (w_lastQ) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.scl_oe      = r_sclOe;
  assign bus.sda_oe      = r_sdaOe;
  assign bus.sended      = r_sended;
  assign bus.received    = r_received;
  assign bus.isReady     = r_isReady;
  assign bus.ackErr      = r_ackErr;
  assign bus.datareceive = r_datareceive;

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_byte_master
// Description : Directed bench for i2c_byte_master with a behavioural I2C
//               slave that logs bus events (S/Sr/P, bytes, A/N).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_byte_master;
  localparam int QDIV = 4;
  localparam int C_S  = 256;
  localparam int C_SR = 257;
  localparam int C_P  = 258;
  localparam int C_A  = 259;
  localparam int C_N  = 260;

  logic clk;
  logic reset;
  i2c_byte_master_if bus ();

  i2c_byte_master #(.QDIV(QDIV), .TOG_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wired-AND SDA line
  logic slvOe;
  assign bus.sda_in = ~(bus.sda_oe | slvOe);

  int checks   = 0;
  int failures = 0;

  // Slave configuration (written by the stimulus only)
  logic ackEn;
  int   rdData [4];

  // Slave state and event log (written by the slave model only)
  int         evLog [$];
  logic       prevScl, prevSda, sclNow, sdaNow;
  logic       slvActive, slvDir, slvFirst, slvAck;
  int         slvBit, rdIdx;
  logic [7:0] slvByte, slvRdByte;

  // Monitor state (written by the monitor only)
  int     sendedRises = 0;
  int     recvRises   = 0;
  int     overlap     = 0;
  longint sclRise [$];
  logic   prevSended = 1'b0, prevRecv = 1'b0, prevSclOe = 1'b0;

  // Behavioural slave: acks writes when ackEn, serves rdData after a read address
  initial begin : slaveModel
    slvOe = 1'b0; prevScl = 1'b1; prevSda = 1'b1; slvActive = 1'b0;
    slvDir = 1'b0; slvFirst = 1'b0; slvAck = 1'b0; slvBit = 0; rdIdx = 0;
    slvByte = 8'h00; slvRdByte = 8'h00;
    forever begin
      @(negedge clk);
      sclNow = ~bus.scl_oe;
      sdaNow = ~(bus.sda_oe | slvOe);
      if (prevScl && sclNow && prevSda && !sdaNow) begin
        evLog.push_back(slvActive ? C_SR : C_S);
        if (!slvActive) rdIdx = 0;
        slvActive = 1'b1; slvBit = 0; slvDir = 1'b0; slvFirst = 1'b1; slvOe = 1'b0;
      end else if (prevScl && sclNow && !prevSda && sdaNow) begin
        evLog.push_back(C_P);
        slvActive = 1'b0; slvOe = 1'b0;
      end else if (slvActive && !prevScl && sclNow) begin
        if (slvBit < 8) slvByte = {slvByte[6:0], sdaNow};
        slvBit++;
        if (slvBit == 8) evLog.push_back(int'(slvByte));
        if (slvBit == 9) begin
          slvAck = !sdaNow;
          evLog.push_back(sdaNow ? C_N : C_A);
        end
      end else if (slvActive && prevScl && !sclNow) begin
        if (slvBit == 8) begin
          slvOe = slvDir ? 1'b0 : ackEn;
        end else if (slvBit == 9) begin
          if (!slvDir && slvFirst && slvByte[0] && slvAck) begin
            slvDir = 1'b1;
            slvRdByte = rdData[rdIdx][7:0];
          end else if (slvDir && slvAck) begin
            if (rdIdx < 3) rdIdx++;
            slvRdByte = rdData[rdIdx][7:0];
          end else begin
            slvDir = 1'b0;
          end
          slvFirst = 1'b0;
          slvBit = 0;
          slvOe = slvDir ? ~slvRdByte[7] : 1'b0;
        end else if (slvDir && slvBit >= 1 && slvBit <= 7) begin
          slvOe = ~slvRdByte[7 - slvBit];
        end else begin
          slvOe = 1'b0;
        end
      end
      prevScl = sclNow;
      prevSda = sdaNow;
    end
  end

  // Pulse counters and SCL rising-edge timestamps
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.sended && !prevSended) sendedRises++;
      if (bus.received && !prevRecv) recvRises++;
      if (bus.sended && bus.received) overlap++;
      if (!bus.scl_oe && prevSclOe) sclRise.push_back($time);
      prevSended = bus.sended;
      prevRecv   = bus.received;
      prevSclOe  = bus.scl_oe;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "bench stopped by watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return bus.sended;
      1:       return bus.received;
      2:       return bus.isReady;
      default: return bus.scl_oe;
    endcase
  endfunction

  task automatic waitLevel(input int sel, input logic lvl, input int budget, input string tag);
    int n;
    n = 0;
    while (pick(sel) !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(pick(sel)), 32'(lvl));
  endtask

  task automatic startTxn(input logic [7:0] data, input string tag);
    bus.start = 1'b1;
    bus.datasend = data;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check({tag, "_busy"}, 32'(bus.isReady), 32'(1'b0));
  endtask

  task automatic sendWindow(input logic st, input logic sd, input logic rc,
                            input logic [7:0] data, input string tag);
    waitLevel(0, 1'b1, 400, {tag, "_sendedUp"});
    bus.start = st; bus.send = sd; bus.receive = rc; bus.datasend = data;
    waitLevel(0, 1'b0, 100, {tag, "_sendedDown"});
    bus.start = 1'b0; bus.send = 1'b0; bus.receive = 1'b0;
  endtask

  task automatic recvWindow(input logic rc, input logic [7:0] expData, input string tag);
    waitLevel(1, 1'b1, 400, {tag, "_receivedUp"});
    check({tag, "_data"}, 32'(bus.datareceive), 32'(expData));
    bus.receive = rc;
    waitLevel(1, 1'b0, 100, {tag, "_receivedDown"});
    bus.receive = 1'b0;
  endtask

  task automatic checkLog(input string tag, input int base, input int exp[$]);
    int got;
    check({tag, "_len"}, evLog.size() - base, exp.size());
    foreach (exp[i]) begin
      got = (base + i < evLog.size()) ? evLog[base + i] : -1;
      check($sformatf("%s_ev%0d", tag, i), got, exp[i]);
    end
  endtask

  initial begin : stimulus
    int base, sBase, rBase, kBase;
    int expQ [$];
    longint d0, d1;

    reset = 1'b0;
    bus.start = 1'b0; bus.send = 1'b0; bus.receive = 1'b0; bus.datasend = 8'h00;
    ackEn = 1'b1;
    rdData[0] = 32'h55; rdData[1] = 32'h00; rdData[2] = 32'h00; rdData[3] = 32'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_scl_oe", 32'(bus.scl_oe), 32'(1'b0));
    check("rst_sda_oe", 32'(bus.sda_oe), 32'(1'b0));
    check("rst_sended", 32'(bus.sended), 32'(1'b0));
    check("rst_received", 32'(bus.received), 32'(1'b0));
    check("rst_datareceive", 32'(bus.datareceive), 32'h00);
    check("rst_isReady", 32'(bus.isReady), 32'(1'b0));
    check("rst_ackErr", 32'(bus.ackErr), 32'(1'b0));
    reset = 1'b1;
    @(negedge clk);
    check("rst_isReady_after", 32'(bus.isReady), 32'(1'b1));

    // IDLE ignores send/receive while start is low
    sBase = sendedRises;
    bus.send = 1'b1; bus.receive = 1'b1; bus.datasend = 8'hA5;
    repeat (3 * 4 * QDIV) @(negedge clk);
    check("idle_isReady", 32'(bus.isReady), 32'(1'b1));
    check("idle_scl_oe", 32'(bus.scl_oe), 32'(1'b0));
    check("idle_sda_oe", 32'(bus.sda_oe), 32'(1'b0));
    check("idle_noSended", sendedRises - sBase, 0);
    bus.send = 1'b0; bus.receive = 1'b0;

    // ID read: S EE A D0 A Sr EF A 55 N P
    base = evLog.size(); sBase = sendedRises; rBase = recvRises;
    startTxn(8'hEE, "id");
    sendWindow(1'b0, 1'b1, 1'b0, 8'hD0, "id_w1");
    sendWindow(1'b1, 1'b0, 1'b0, 8'hEF, "id_w2");
    sendWindow(1'b0, 1'b0, 1'b1, 8'h00, "id_w3");
    recvWindow(1'b0, 8'h55, "id_r1");
    waitLevel(2, 1'b1, 400, "id_isReady");
    expQ = '{C_S, 32'hEE, C_A, 32'hD0, C_A, C_SR, 32'hEF, C_A, 32'h55, C_N, C_P};
    checkLog("id_bus", base, expQ);
    check("id_datareceive", 32'(bus.datareceive), 32'h55);
    check("id_sendedPulses", sendedRises - sBase, 3);
    check("id_receivedPulses", recvRises - rBase, 1);
    check("id_ackErr", 32'(bus.ackErr), 32'(1'b0));

    // Burst read: AA A BB A CC N P
    rdData[0] = 32'hAA; rdData[1] = 32'hBB; rdData[2] = 32'hCC;
    base = evLog.size(); rBase = recvRises;
    startTxn(8'hEE, "burst");
    sendWindow(1'b0, 1'b1, 1'b0, 8'hD0, "burst_w1");
    sendWindow(1'b1, 1'b0, 1'b0, 8'hEF, "burst_w2");
    sendWindow(1'b0, 1'b0, 1'b1, 8'h00, "burst_w3");
    recvWindow(1'b1, 8'hAA, "burst_r1");
    recvWindow(1'b1, 8'hBB, "burst_r2");
    recvWindow(1'b0, 8'hCC, "burst_r3");
    waitLevel(2, 1'b1, 400, "burst_isReady");
    expQ = '{C_S, 32'hEE, C_A, 32'hD0, C_A, C_SR, 32'hEF, C_A,
             32'hAA, C_A, 32'hBB, C_A, 32'hCC, C_N, C_P};
    checkLog("burst_bus", base, expQ);
    check("burst_datareceive", 32'(bus.datareceive), 32'hCC);
    check("burst_receivedPulses", recvRises - rBase, 3);

    // Address NACK: send=1 in the window must still lead to STOP
    ackEn = 1'b0;
    base = evLog.size(); sBase = sendedRises;
    startTxn(8'hEE, "nack");
    waitLevel(0, 1'b1, 400, "nack_sendedUp");
    check("nack_ackErr", 32'(bus.ackErr), 32'(1'b1));
    bus.send = 1'b1; bus.datasend = 8'hD0;
    waitLevel(0, 1'b0, 100, "nack_sendedDown");
    bus.send = 1'b0;
    waitLevel(2, 1'b1, 400, "nack_isReady");
    expQ = '{C_S, 32'hEE, C_N, C_P};
    checkLog("nack_bus", base, expQ);
    check("nack_sendedPulses", sendedRises - sBase, 1);
    check("nack_ackErrHeld", 32'(bus.ackErr), 32'(1'b1));
    ackEn = 1'b1;
    base = evLog.size();
    startTxn(8'hEE, "reack");
    check("reack_ackErrCleared", 32'(bus.ackErr), 32'(1'b0));
    sendWindow(1'b0, 1'b0, 1'b0, 8'h00, "reack_w1");
    waitLevel(2, 1'b1, 400, "reack_isReady");
    expQ = '{C_S, 32'hEE, C_A, C_P};
    checkLog("reack_bus", base, expQ);

    // Write then stop, with SCL period measurement
    base = evLog.size(); sBase = sendedRises; kBase = sclRise.size();
    startTxn(8'hEE, "wr");
    sendWindow(1'b0, 1'b1, 1'b0, 8'hF4, "wr_w1");
    sendWindow(1'b0, 1'b1, 1'b0, 8'h2E, "wr_w2");
    sendWindow(1'b0, 1'b0, 1'b0, 8'h00, "wr_w3");
    waitLevel(2, 1'b1, 400, "wr_isReady");
    expQ = '{C_S, 32'hEE, C_A, 32'hF4, C_A, 32'h2E, C_A, C_P};
    checkLog("wr_bus", base, expQ);
    check("wr_sendedPulses", sendedRises - sBase, 3);
    d0 = (sclRise.size() > kBase + 2) ? sclRise[kBase + 1] - sclRise[kBase] : 0;
    d1 = (sclRise.size() > kBase + 2) ? sclRise[kBase + 2] - sclRise[kBase + 1] : 0;
    check("wr_sclPeriod0", 32'(d0), 32'(4 * QDIV * 10));
    check("wr_sclPeriod1", 32'(d1), 32'(4 * QDIV * 10));
    check("all_noOverlap", overlap, 0);

    // Asynchronous reset in the middle of the address byte
    startTxn(8'hEE, "arst");
    repeat (20) @(negedge clk);
    waitLevel(3, 1'b1, 40, "arst_sclLowSeen");
    #2;
    reset = 1'b0;
    #1;
    check("arst_scl_oe", 32'(bus.scl_oe), 32'(1'b0));
    check("arst_sda_oe", 32'(bus.sda_oe), 32'(1'b0));
    check("arst_sended", 32'(bus.sended), 32'(1'b0));
    check("arst_received", 32'(bus.received), 32'(1'b0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_isReadyLow", 32'(bus.isReady), 32'(1'b0));
    @(negedge clk);
    check("arst_isReadyHigh", 32'(bus.isReady), 32'(1'b1));
    check("arst_linesReleased", 32'({bus.scl_oe, bus.sda_oe}), 32'(2'b00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
